// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral interconnect.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam logic [31:0] DECERR_RD = 32'h0;

  localparam int SLOT_DMEM = 0;
  localparam int SLOT_PS2  = 3;
  localparam int SLOT_VGA  = 7;

  // Slot index width; a single slave still needs one select bit.
  function automatic int slotWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/periph_bus_ic_if.sv
// Bus bundle between the LSU, the interconnect, the slaves and the core IRQ lines.
interface periph_bus_ic_if #(
  parameter int N_SLAVES = 8
);
  logic                    m_req_i;
  logic                    m_we_i;
  logic [3:0]              m_be_i;
  logic [31:0]             m_addr_i;
  logic [31:0]             m_wd_i;
  logic [31:0]             m_rd_o;
  logic                    m_ready_o;
  logic                    m_err_o;

  logic [N_SLAVES-1:0]     s_req_o;
  logic                    s_we_o;
  logic [3:0]              s_be_o;
  logic [31:0]             s_addr_o;
  logic [31:0]             s_wd_o;
  logic [32*N_SLAVES-1:0]  s_rd_i;
  logic [N_SLAVES-1:0]     s_ready_i;

  logic [N_SLAVES-1:0]     s_irq_i;
  logic                    irq_req_o;
  logic [7:0]              irq_id_o;
  logic                    irq_ret_i;
  logic [N_SLAVES-1:0]     irq_ret_o;

  // Interconnect view: serves the LSU and drives the slave side.
  modport slave (
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wd_i,
    output m_rd_o, m_ready_o, m_err_o,
    output s_req_o, s_we_o, s_be_o, s_addr_o, s_wd_o,
    input  s_rd_i, s_ready_i, s_irq_i,
    output irq_req_o, irq_id_o, irq_ret_o,
    input  irq_ret_i
  );

  // Environment view: LSU, peripherals and core together.
  modport master (
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wd_i,
    input  m_rd_o, m_ready_o, m_err_o,
    input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wd_o,
    output s_rd_i, s_ready_i, s_irq_i,
    input  irq_req_o, irq_id_o, irq_ret_o,
    output irq_ret_i
  );
endinterface

// File: rtl/periph_irq_arb.sv
// Fixed-priority interrupt aggregator: lowest pending slot wins and is held
// until the core returns, then the return pulse goes back to that slot.
module periph_irq_arb
  import periph_bus_pkg::*;
#(
  parameter int                  N_SLAVES = 8,
  parameter logic [N_SLAVES-1:0] IRQ_MASK = 8'b0000_1000
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic [N_SLAVES-1:0] i_irq,
  input  logic                i_ret,
  output logic                o_req,
  output logic [7:0]          o_id,
  output logic [N_SLAVES-1:0] o_ret
);

  logic [N_SLAVES-1:0] w_pend;
  logic [7:0]          w_lowId;
  logic [N_SLAVES-1:0] w_retVec;

  logic                r_req;
  logic [7:0]          r_id;
  logic                r_lock;
  logic [N_SLAVES-1:0] r_ret;

  always_comb begin
    w_pend   = i_irq & IRQ_MASK;
    w_lowId  = '0;
    w_retVec = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_pend[i]) w_lowId = 8'(i);
    end
    for (int i = 0; i < N_SLAVES; i++) begin
      w_retVec[i] = (r_id == 8'(i));
    end
  end

  // The id is frozen while locked; a return unlocks and the pick resumes next cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_req  <= 1'b0;
      r_id   <= '0;
      r_lock <= 1'b0;
      r_ret  <= '0;
    end else begin
      r_req <= |w_pend;
      if (i_ret) begin
        r_ret  <= w_retVec;
        r_lock <= 1'b0;
      end else begin
        r_ret <= '0;
        if (!r_lock && (|w_pend)) begin
          r_id   <= w_lowId;
          r_lock <= 1'b1;
        end
      end
    end
  end

  assign o_req = r_req;
  assign o_id  = r_id;
  assign o_ret = r_ret;

endmodule

// File: rtl/periph_bus_ic.sv
// Peripheral interconnect: decodes the slot field of the LSU address, forwards
// the request to one slave, waits for ready with a timeout and returns the response.
module periph_bus_ic
  import periph_bus_pkg::*;
#(
  parameter int                  N_SLAVES   = 8,
  parameter int                  SEL_LSB    = 24,
  parameter logic [N_SLAVES-1:0] SLAVE_MASK = 8'b1000_1001,
  parameter logic [N_SLAVES-1:0] IRQ_MASK   = 8'b0000_1000,
  parameter int                  TIMEOUT    = 255
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  periph_bus_ic_if.slave bus
);

  localparam int          SLOT_W   = slotWidth(N_SLAVES);
  localparam logic [31:0] LOW_MASK = 32'((64'd1 << SEL_LSB) - 64'd1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]          r_state;
  logic                r_we;
  logic [3:0]          r_be;
  logic [31:0]         r_addr;
  logic [31:0]         r_wd;
  logic [SLOT_W-1:0]   r_slot;
  logic [15:0]         r_cnt;
  logic [31:0]         r_rd;
  logic                r_err;

  logic [31:0]         w_field;
  logic                w_hit;
  logic                w_slvReady;
  logic [31:0]         w_slvRd;
  logic [N_SLAVES-1:0] w_sReq;

  assign w_field = bus.m_addr_i >> SEL_LSB;

  // The whole upper field is range-checked so stray high bits never alias a slot.
  always_comb begin
    w_hit = 1'b0;
    if (w_field < 32'(N_SLAVES)) w_hit = SLAVE_MASK[w_field[SLOT_W-1:0]];
  end

  always_comb begin
    w_slvReady = 1'b0;
    w_slvRd    = '0;
    w_sReq     = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_slot == SLOT_W'(i)) begin
        w_slvReady = bus.s_ready_i[i];
        w_slvRd    = bus.s_rd_i[32*i +: 32];
        w_sReq[i]  = (r_state == S_WAIT);
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_slot  <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd  <= '0;
          r_err <= 1'b0;
          if (bus.m_req_i) begin
            r_we   <= bus.m_we_i;
            r_be   <= bus.m_be_i;
            r_addr <= bus.m_addr_i & LOW_MASK;
            r_wd   <= bus.m_wd_i;
            r_slot <= w_field[SLOT_W-1:0];
            r_cnt  <= '0;
            if (w_hit) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
              r_rd    <= DECERR_RD;
            end
          end
        end
        S_WAIT: begin
          if (w_slvReady) begin
            r_rd    <= w_slvRd;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == 16'(TIMEOUT - 1)) begin
            r_rd    <= DECERR_RD;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_rd    <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_ready_o = (r_state == S_RESP);
  assign bus.m_rd_o    = r_rd;
  assign bus.m_err_o   = r_err;
  assign bus.s_req_o   = w_sReq;
  assign bus.s_we_o    = r_we;
  assign bus.s_be_o    = r_be;
  assign bus.s_addr_o  = r_addr;
  assign bus.s_wd_o    = r_wd;

  periph_irq_arb #(
    .N_SLAVES (N_SLAVES),
    .IRQ_MASK (IRQ_MASK)
  ) u_irqArb (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .i_irq    (bus.s_irq_i),
    .i_ret    (bus.irq_ret_i),
    .o_req    (bus.irq_req_o),
    .o_id     (bus.irq_id_o),
    .o_ret    (bus.irq_ret_o)
  );

endmodule

// File: tb/tb_periph_bus_ic.sv
// Self-checking bench for periph_bus_ic: directed vector table, randomized
// transactions and interrupts against a behavioural model, and reset corners.
module tb_periph_bus_ic;

  localparam int         N          = 8;
  localparam int         TMO        = 4;
  localparam logic [7:0] SLAVE_MASK = 8'b1000_1001;
  localparam logic [7:0] IRQ_MASK   = 8'b1000_1000;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    int          delay;
  } txnIn_t;

  typedef struct {
    int          lat;
    int          reqCycles;
    logic [7:0]  reqSeen;
    logic [31:0] rd;
    logic        err;
    logic [31:0] sAddr;
    logic [3:0]  sBe;
    logic        sWe;
    logic [31:0] sWd;
    logic        timedOut;
    logic        extraReady;
    logic [31:0] rdIdle;
  } txnOut_t;

  typedef struct {
    txnIn_t  in;
    txnOut_t exp;
  } vec_t;

  logic clk;
  logic resetn;
  int   compared;
  int   mismatched;
  logic [31:0] slotData [N];

  periph_bus_ic_if #(.N_SLAVES(N)) bus ();

  periph_bus_ic #(
    .N_SLAVES   (N),
    .SEL_LSB    (24),
    .SLAVE_MASK (SLAVE_MASK),
    .IRQ_MASK   (IRQ_MASK),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic txnIn_t mkIn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                  input logic [31:0] wd, input int delay);
    txnIn_t t;
    t.addr = addr; t.we = we; t.be = be; t.wd = wd; t.delay = delay;
    return t;
  endfunction

  function automatic txnOut_t blankOut();
    txnOut_t o;
    o.lat = 0; o.reqCycles = 0; o.reqSeen = '0; o.rd = '0; o.err = 1'b0;
    o.sAddr = '0; o.sBe = '0; o.sWe = 1'b0; o.sWd = '0;
    o.timedOut = 1'b0; o.extraReady = 1'b0; o.rdIdle = '0;
    return o;
  endfunction

  function automatic txnOut_t mkExp(input int lat, input int rc, input logic [7:0] seen,
                                    input logic [31:0] rd, input logic err, input logic [31:0] sAddr,
                                    input logic [3:0] sBe, input logic sWe, input logic [31:0] sWd);
    txnOut_t o;
    o = blankOut();
    o.lat = lat; o.reqCycles = rc; o.reqSeen = seen; o.rd = rd; o.err = err;
    o.sAddr = sAddr; o.sBe = sBe; o.sWe = sWe; o.sWd = sWd;
    return o;
  endfunction

  // Reference: latency counts clock edges from the one that samples the request
  // to the one after which m_ready_o is seen (request cycle plus that many cycles).
  function automatic txnOut_t modelTxn(input txnIn_t v);
    txnOut_t o;
    int slot;
    o = blankOut();
    slot = int'(v.addr >> 24);
    if (slot >= N || !SLAVE_MASK[slot]) begin
      o.lat = 1; o.err = 1'b1; o.rd = 32'h0;
    end else begin
      o.reqSeen = 8'h1 << slot;
      o.sAddr = v.addr & 32'h00FF_FFFF;
      o.sBe = v.be; o.sWe = v.we; o.sWd = v.wd;
      if (v.delay < TMO) begin
        o.lat = v.delay + 2; o.reqCycles = v.delay + 1; o.rd = slotData[slot];
      end else begin
        o.lat = TMO + 1; o.reqCycles = TMO; o.err = 1'b1; o.rd = 32'h0;
      end
    end
    return o;
  endfunction

  task automatic driveSlotData();
    for (int i = 0; i < N; i++) bus.s_rd_i[32*i +: 32] = slotData[i];
  endtask

  // Slave answers in its (delay+1)-th cycle of seeing s_req_o.
  task automatic applyStimulus(input txnIn_t v, output txnOut_t o);
    bit done;
    o = blankOut();
    done = 0;
    @(negedge clk);
    bus.m_addr_i  = v.addr;
    bus.m_we_i    = v.we;
    bus.m_be_i    = v.be;
    bus.m_wd_i    = v.wd;
    bus.m_req_i   = 1'b1;
    bus.s_ready_i = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      o.lat++;
      if (bus.s_req_o != '0) begin
        o.reqCycles++;
        o.reqSeen |= bus.s_req_o;
        o.sAddr = bus.s_addr_o; o.sBe = bus.s_be_o; o.sWe = bus.s_we_o; o.sWd = bus.s_wd_o;
      end
      if (bus.m_ready_o) begin
        done = 1; o.rd = bus.m_rd_o; o.err = bus.m_err_o;
      end
      bus.s_ready_i = (bus.s_req_o != '0 && o.reqCycles == v.delay + 1) ? bus.s_req_o : '0;
    end
    if (!done) o.timedOut = 1'b1;
    bus.s_ready_i = '0;
    @(posedge clk); #1;
    o.extraReady = bus.m_ready_o;
    o.rdIdle     = bus.m_rd_o;
    bus.m_req_i  = 1'b0;
  endtask

  task automatic compareTxn(input string tag, input txnOut_t act, input txnOut_t exp);
    checkOutput({tag, " timeout"}, 64'(act.timedOut), 64'(exp.timedOut));
    checkOutput({tag, " latency"}, 64'(act.lat), 64'(exp.lat));
    checkOutput({tag, " s_req cycles"}, 64'(act.reqCycles), 64'(exp.reqCycles));
    checkOutput({tag, " s_req slots"}, 64'(act.reqSeen), 64'(exp.reqSeen));
    checkOutput({tag, " m_rd"}, 64'(act.rd), 64'(exp.rd));
    checkOutput({tag, " m_err"}, 64'(act.err), 64'(exp.err));
    checkOutput({tag, " second ready"}, 64'(act.extraReady), 64'(exp.extraReady));
    checkOutput({tag, " m_rd idle"}, 64'(act.rdIdle), 64'(exp.rdIdle));
    if (exp.reqSeen != '0) begin
      checkOutput({tag, " s_addr"}, 64'(act.sAddr), 64'(exp.sAddr));
      checkOutput({tag, " s_be"}, 64'(act.sBe), 64'(exp.sBe));
      checkOutput({tag, " s_we"}, 64'(act.sWe), 64'(exp.sWe));
      checkOutput({tag, " s_wd"}, 64'(act.sWd), 64'(exp.sWd));
    end
  endtask

  initial begin
    vec_t    table_q [8];
    txnOut_t obs;
    txnIn_t  v;
    logic [7:0] pend;
    int      expId;
    bit      sawAny;

    compared = 0; mismatched = 0;
    clk = 1'b0; resetn = 1'b0;
    bus.m_req_i = 1'b0; bus.m_we_i = 1'b0; bus.m_be_i = '0; bus.m_addr_i = '0; bus.m_wd_i = '0;
    bus.s_rd_i = '0; bus.s_ready_i = '0; bus.s_irq_i = '0; bus.irq_ret_i = 1'b0;
    for (int i = 0; i < N; i++) slotData[i] = 32'hD0D0_0000 | 32'(i);
    slotData[0] = 32'hCAFE_0001; slotData[3] = 32'h3333_0003; slotData[7] = 32'h7777_0007;
    driveSlotData();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset m_ready", 64'(bus.m_ready_o), 64'd0);
    checkOutput("reset m_rd", 64'(bus.m_rd_o), 64'd0);
    checkOutput("reset m_err", 64'(bus.m_err_o), 64'd0);
    checkOutput("reset s_req", 64'(bus.s_req_o), 64'd0);
    checkOutput("reset s_addr", 64'(bus.s_addr_o), 64'd0);
    checkOutput("reset irq_req", 64'(bus.irq_req_o), 64'd0);
    checkOutput("reset irq_id", 64'(bus.irq_id_o), 64'd0);
    checkOutput("reset irq_ret", 64'(bus.irq_ret_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    table_q[0] = '{mkIn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0),
                   mkExp(2, 1, 8'h01, 32'hCAFE_0001, 1'b0, 32'h10, 4'hF, 1'b0, 32'h0)};
    table_q[1] = '{mkIn(32'h0700_0004, 1'b1, 4'b0011, 32'h1234, 0),
                   mkExp(2, 1, 8'h80, 32'h7777_0007, 1'b0, 32'h4, 4'b0011, 1'b1, 32'h1234)};
    table_q[2] = '{mkIn(32'h0500_0000, 1'b0, 4'hF, 32'h0, 0),
                   mkExp(1, 0, 8'h00, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0)};
    table_q[3] = '{mkIn(32'h0900_0000, 1'b0, 4'hF, 32'h0, 0),
                   mkExp(1, 0, 8'h00, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0)};
    table_q[4] = '{mkIn(32'h0300_0020, 1'b0, 4'hF, 32'h0, 10),
                   mkExp(5, 4, 8'h08, 32'h0, 1'b1, 32'h20, 4'hF, 1'b0, 32'h0)};
    table_q[5] = '{mkIn(32'h0300_0008, 1'b1, 4'b1100, 32'hABCD, 3),
                   mkExp(5, 4, 8'h08, 32'h3333_0003, 1'b0, 32'h8, 4'b1100, 1'b1, 32'hABCD)};
    table_q[6] = '{mkIn(32'hFF12_3456, 1'b1, 4'hF, 32'h55, 0),
                   mkExp(1, 0, 8'h00, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0)};
    table_q[7] = '{mkIn(32'h0000_0000, 1'b0, 4'hF, 32'h0, 1),
                   mkExp(3, 2, 8'h01, 32'hCAFE_0001, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0)};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(table_q[i].in, obs);
      compareTxn($sformatf("vec%0d", i), obs, table_q[i].exp);
    end

    for (int k = 0; k < 30; k++) begin
      logic [7:0] slotByte;
      slotByte = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      for (int i = 0; i < N; i++) slotData[i] = $urandom;
      driveSlotData();
      v = mkIn({slotByte, 24'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
               int'($urandom_range(0, 6)));
      applyStimulus(v, obs);
      compareTxn($sformatf("rnd%0d", k), obs, modelTxn(v));
    end

    // Reset in the middle of a slave wait must drop the request silently.
    @(negedge clk);
    bus.m_addr_i = 32'h0300_0044; bus.m_we_i = 1'b0; bus.m_be_i = 4'hF; bus.m_req_i = 1'b1;
    bus.s_ready_i = '0;
    @(posedge clk); #1;
    checkOutput("rst pre s_req", 64'(bus.s_req_o), 64'h08);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst s_req drop", 64'(bus.s_req_o), 64'h0);
    checkOutput("rst s_addr clear", 64'(bus.s_addr_o), 64'h0);
    bus.m_req_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sawAny = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.m_ready_o || bus.s_req_o != '0) sawAny = 1;
    end
    checkOutput("rst no response", 64'(sawAny), 64'd0);
    slotData[0] = 32'hCAFE_0001;
    driveSlotData();
    applyStimulus(table_q[0].in, obs);
    compareTxn("post-rst", obs, table_q[0].exp);

    // Interrupt priority, lock while in service, and return routing.
    @(posedge clk); #1;
    bus.s_irq_i = 8'h88;
    @(posedge clk); #1;
    checkOutput("irq req", 64'(bus.irq_req_o), 64'd1);
    checkOutput("irq id first", 64'(bus.irq_id_o), 64'd3);
    bus.s_irq_i = 8'h80;
    @(posedge clk); #1;
    checkOutput("irq id locked", 64'(bus.irq_id_o), 64'd3);
    bus.irq_ret_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("irq ret slot3", 64'(bus.irq_ret_o), 64'h08);
    bus.irq_ret_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("irq id next", 64'(bus.irq_id_o), 64'd7);
    checkOutput("irq ret pulse", 64'(bus.irq_ret_o), 64'h0);
    bus.s_irq_i = 8'h00;
    bus.irq_ret_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("irq ret slot7", 64'(bus.irq_ret_o), 64'h80);
    bus.irq_ret_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("irq req idle", 64'(bus.irq_req_o), 64'd0);

    expId = 7;
    for (int k = 0; k < 12; k++) begin
      bus.s_irq_i = 8'($urandom);
      pend = bus.s_irq_i & IRQ_MASK;
      @(posedge clk); #1;
      checkOutput($sformatf("rnd irq%0d req", k), 64'(bus.irq_req_o), 64'(pend != 0));
      if (pend != 0) begin
        for (int i = N - 1; i >= 0; i--) if (pend[i]) expId = i;
        checkOutput($sformatf("rnd irq%0d id", k), 64'(bus.irq_id_o), 64'(expId));
        bus.irq_ret_i = 1'b1;
        @(posedge clk); #1;
        checkOutput($sformatf("rnd irq%0d ret", k), 64'(bus.irq_ret_o), 64'(8'h1 << expId));
        bus.irq_ret_i = 1'b0;
      end
      bus.s_irq_i = '0;
      @(posedge clk); #1;
      checkOutput($sformatf("rnd irq%0d ret idle", k), 64'(bus.irq_ret_o), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
